// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: one bus master's request/ack handshake into the SRAM arbiter.
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) ();
  logic                  req;
  logic                  we;
  logic [NUM_WMASKS-1:0] sel;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (output req, we, sel, addr, wdata, input ack, rdata);
  modport slave (input req, we, sel, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares a 1r1w SRAM macro between two masters, round-robin per port,
// with registered macro outputs and a same-address read-behind-write hold-off.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  sram_port_arbiter_if.slave    m0,
  sram_port_arbiter_if.slave    m1,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  typedef enum logic [2:0] {IDLE, WR_ISSUED, RD_ISSUED, RD_CAPT, ACK} state_t;
  state_t                st [2];
  state_t                st_nxt [2];
  logic [1:0]            req, we, wcand, rcand, wgnt, rwin, rgnt;
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [NUM_WMASKS-1:0] sel [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic                  wptr, rptr, hazard;
  assign req = {m1.req, m0.req};
  assign we = {m1.we, m0.we};
  assign addr[0] = m0.addr;
  assign addr[1] = m1.addr;
  assign sel[0] = m0.sel;
  assign sel[1] = m1.sel;
  assign wdata[0] = m0.wdata;
  assign wdata[1] = m1.wdata;
  assign m0.ack = st[0] == ACK;
  assign m1.ack = st[1] == ACK;
  assign m0.rdata = rdata[0];
  assign m1.rdata = rdata[1];
  // ptr=0 favours m0; a contested port's winner is always the pointer holder
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wcand[i] = st[i] == IDLE && req[i] && we[i];
      rcand[i] = st[i] == IDLE && req[i] && !we[i];
    end
    wgnt = &wcand ? (wptr ? 2'b10 : 2'b01) : wcand;
    rwin = &rcand ? (rptr ? 2'b10 : 2'b01) : rcand;
    hazard = |wgnt && |rwin && addr[wgnt[1]] == addr[rwin[1]];
    rgnt = hazard ? 2'b00 : rwin;
  end
  always_comb begin
    for (int i = 0; i < 2; i++)
      st_nxt[i] = st[i] == IDLE      ? (wgnt[i] ? WR_ISSUED : rgnt[i] ? RD_ISSUED : IDLE) :
                  st[i] == RD_ISSUED ? RD_CAPT :
                  st[i] == ACK       ? IDLE : ACK;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st[0] <= IDLE;
      st[1] <= IDLE;
      wptr <= 1'b0;
      rptr <= 1'b0;
      sram_csb0 <= 1'b1;
      sram_csb1 <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0 <= '0;
      sram_din0 <= '0;
      sram_addr1 <= '0;
      rdata[0] <= '0;
      rdata[1] <= '0;
    end else begin
      st <= st_nxt;
      if (&wcand) wptr <= ~wptr;
      if (&rcand && !hazard) rptr <= ~rptr;
      sram_csb0 <= ~|wgnt;
      sram_csb1 <= ~|rgnt;
      if (|wgnt) begin
        sram_wmask0 <= sel[wgnt[1]];
        sram_addr0 <= addr[wgnt[1]];
        sram_din0 <= wdata[wgnt[1]];
      end
      if (|rgnt) sram_addr1 <= addr[rgnt[1]];
      for (int i = 0; i < 2; i++)
        if (st[i] == RD_CAPT) rdata[i] <= sram_dout1;
    end
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one 32x2048 1r1w SRAM macro (write port 0, read port 1) between two bus masters, m0 and m1.
- Typical pairing: m0 is the CPU data side, m1 is the DMA/Wishbone side.
- Arbitrates the write and read ports independently with round-robin priority and tracks each master's outstanding transaction.
- Blocks a read from sampling the same word that is being written in the same macro cycle.
- All macro-side signals are registered. The macro's clk0/clk1 are tied to clk outside this block.

Parameters:
- ADDR_WIDTH, 11, word address width.
- DATA_WIDTH, 32, data width.
- NUM_WMASKS, 4, byte-lane write-mask width (DATA_WIDTH/8).

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- mN_req  in  1  request (N=0,1); held stable until mN_ack.
- mN_we  in  1  1=write, 0=read.
- mN_sel  in  NUM_WMASKS  byte enables (writes only).
- mN_addr  in  ADDR_WIDTH  word address.
- mN_wdata  in  DATA_WIDTH  write data.
- mN_ack  out  1  one-cycle completion pulse.
- mN_rdata  out  DATA_WIDTH  read data, valid while mN_ack=1 after a read.
- sram_csb0  out  1  write-port chip select, active low.
- sram_wmask0  out  NUM_WMASKS  write mask.
- sram_addr0  out  ADDR_WIDTH  write address.
- sram_din0  out  DATA_WIDTH  write data.
- sram_csb1  out  1  read-port chip select, active low.
- sram_addr1  out  ADDR_WIDTH  read address.
- sram_dout1  in  DATA_WIDTH  read data from macro.

Behaviour:
- Reset values (asynchronous, while nrst=0):
  - sram_csb0=1, sram_csb1=1; sram_wmask0, sram_addr0, sram_din0, sram_addr1 = 0.
  - mN_ack=0, mN_rdata=0.
  - Both master FSMs IDLE; both round-robin pointers favour m0.
- Per-master FSM states:
  - IDLE: eligible for grant.
  - WR_ISSUED: goes to ACK.
  - RD_ISSUED: goes to RD_CAPT.
  - RD_CAPT: goes to ACK.
  - ACK: goes to IDLE.
  - In ACK, mN_req is ignored, so a request still held in that cycle is never re-granted. A new request is considered from the cycle after ack.
- Eligibility: a master is eligible only when it is IDLE with req=1. It is a write candidate if we=1 and a read candidate if we=0.
- Write-port arbitration:
  - One candidate: granted.
  - Two candidates: the pointer holder wins, and the pointer then moves to the loser.
  - An uncontested grant leaves the pointer unchanged.
  - On grant at edge E0: sram_csb0=0, and wmask0/addr0/din0 take the winner's sel/addr/wdata. The winner goes to WR_ISSUED.
- Read port: same arbitration with its own pointer. On grant at E0: sram_csb1=0, sram_addr1=addr, winner goes to RD_ISSUED.
- One master can win the write port while the other wins the read port in the same cycle.
- Same-address hazard: if the write winner and read winner in a cycle have equal addresses, the read grant is withheld for that cycle. The read is re-arbitrated next cycle; the read pointer does not move.
- Deassertion: any port not granted at an edge has csb=1 for the following cycle. The other macro outputs hold their last values.
- Latency, counted in posedges from the grant edge E0:
  - Macro samples its inputs at E1.
  - Write: mN_ack=1 for the cycle after E1.
  - Read: sram_dout1 is captured into mN_rdata at E2, and mN_ack=1 for the cycle after E2.
  - mN_rdata holds its value until the next read completion for that master; a write ack does not change it.
- Back-to-back: a master's next grant occurs no earlier than the edge ending its ACK cycle. Per-master throughput is therefore 1 write per 3 cycles and 1 read per 4 cycles. The ports pipeline across masters.
- Byte masking: sel=0000 on a write is a legal no-op. csb0 still asserts with wmask=0 and the ack still occurs.
- Reset mid-operation: in-flight transactions are dropped and no ack is issued. Master FSMs and pointers return to their reset values. Memory contents are undefined for a write whose macro sample edge coincided with reset.
- Protocol violation: a req/we/addr change before ack is undefined. It is not checked.

Test Plan:
- Single write then read: m0 writes addr 0x005, sel=1111, data 0xDEADBEEF. m0_ack comes 2 edges after request; sram_csb0 is low for exactly 1 cycle. m0 then reads 0x005: m0_ack comes 3 edges after request with m0_rdata=0xDEADBEEF.
- Byte mask: m1 writes 0x010 with data 0xAABBCCDD, sel=1111, then 0x11223344 with sel=0101, then reads. Required m1_rdata=0xAA22CC44.
- Contention: m0 and m1 both write in the same cycle, repeated 4 times. Grants alternate m0, m1, m0, m1, starting with m0 after reset. No lost acks.
- Parallel ports:
  - m0 writes 0x020 while m1 reads 0x030 in the same cycle: both granted that cycle.
  - m0 writes 0x040 while m1 reads 0x040: m1's read is granted one cycle later, and m1_rdata equals the newly written value.
- Held req at ack: m0 keeps req=1 through its ack cycle. Exactly one transaction is issued per ack; no duplicate csb assertion.
- Reset mid-read: assert nrst=0 during RD_CAPT. Immediately sram_csb0/csb1=1 and m*_ack=0; no ack after release; the next request behaves as after power-up.
